// File: rtl/redmule_tcdm_arbiter_if.sv
// TCDM master port bundle: request/payload channel plus the in-order read response channel.
interface redmule_tcdm_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 288
);
  logic                req;
  logic                gnt;
  logic                wen;
  logic [ADDR_W-1:0]   add;
  logic [DATA_W-1:0]   data;
  logic [DATA_W/8-1:0] be;
  logic                r_valid;
  logic [DATA_W-1:0]   r_data;

  modport master (output req, wen, add, data, be, input gnt, r_valid, r_data);
  modport slave  (input req, wen, add, data, be, output gnt, r_valid, r_data);
endinterface

// File: rtl/redmule_tcdm_arbiter.sv
// Shares one TCDM port between the X/W/Y load streams and the Z store stream, and routes
// the in-order read responses back to the load source that issued each read.
module redmule_tcdm_arbiter #(
  parameter int unsigned DATA_W     = 288,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MAX_OUTST  = 4,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      z_priority_i,
  input  logic [2:0]                ld_req_i,
  output logic [2:0]                ld_gnt_o,
  input  logic [2:0][ADDR_W-1:0]    ld_addr_i,
  output logic [2:0]                ld_rvalid_o,
  output logic [DATA_W-1:0]         ld_rdata_o,
  input  logic                      st_req_i,
  output logic                      st_gnt_o,
  input  logic [ADDR_W-1:0]         st_addr_i,
  input  logic [DATA_W-1:0]         st_data_i,
  input  logic [DATA_W/8-1:0]       st_be_i,
  redmule_tcdm_arbiter_if.master    tcdm,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTST);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIM + 1);

  logic [1:0]       rr_r;
  logic             lock_r;
  logic [1:0]       lock_idx_r;
  logic [STV_W-1:0] starve_r;
  logic [1:0]       id_mem_r [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             err_r;

  logic       ld_full_s;
  logic [3:0] elig_s;
  logic [3:0] load_elig_s;
  logic [2:0] rr_all_s;
  logic [2:0] rr_ld_s;
  logic       starve_sat_s;
  logic       sel_valid_s;
  logic [1:0] sel_idx_s;
  logic       hs_s;
  logic       ld_hs_s;
  logic       pop_s;
  logic       spurious_s;

  // First set bit of mask at or after ptr, wrapping 3->0; result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign ld_full_s    = (count_r >= CNT_W'(MAX_OUTST));
  assign elig_s       = {st_req_i, ld_req_i & {3{~ld_full_s}}};
  assign load_elig_s  = {1'b0, elig_s[2:0]};
  assign rr_all_s     = rr_pick(elig_s, rr_r);
  assign rr_ld_s      = rr_pick(load_elig_s, rr_r);
  assign starve_sat_s = (starve_r >= STV_W'(STARVE_LIM));
  assign hs_s         = sel_valid_s & tcdm.gnt;
  assign ld_hs_s      = hs_s & (sel_idx_s != 2'd3);
  assign pop_s        = rst_ni & tcdm.r_valid & (count_r != {CNT_W{1'b0}});
  assign spurious_s   = tcdm.r_valid & (count_r == {CNT_W{1'b0}});
  assign busy_o       = (|ld_req_i) | st_req_i | (count_r != {CNT_W{1'b0}});
  assign err_o        = err_r;
  assign ld_rdata_o   = tcdm.r_data;

  // Requester selection: a stalled request stays locked so later arrivals cannot preempt it.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_idx_s   = 2'd0;
    if (clear_i || !rst_ni) begin
      sel_valid_s = 1'b0;
    end else if (lock_r) begin
      sel_valid_s = 1'b1;
      sel_idx_s   = lock_idx_r;
    end else if (!z_priority_i) begin
      {sel_valid_s, sel_idx_s} = rr_all_s;
    end else if (starve_sat_s && (|load_elig_s)) begin
      {sel_valid_s, sel_idx_s} = rr_ld_s;
    end else if (elig_s[3]) begin
      sel_valid_s = 1'b1;
      sel_idx_s   = 2'd3;
    end else begin
      {sel_valid_s, sel_idx_s} = rr_ld_s;
    end
  end

  // Payload mux and same-cycle grant back to the selected requester.
  always_comb begin
    tcdm.req  = sel_valid_s;
    tcdm.wen  = 1'b1;
    tcdm.add  = ld_addr_i[0];
    tcdm.data = {DATA_W{1'b0}};
    tcdm.be   = {(DATA_W/8){1'b1}};
    ld_gnt_o  = 3'b000;
    st_gnt_o  = 1'b0;
    case (sel_idx_s)
      2'd0: begin tcdm.add = ld_addr_i[0]; ld_gnt_o[0] = hs_s; end
      2'd1: begin tcdm.add = ld_addr_i[1]; ld_gnt_o[1] = hs_s; end
      2'd2: begin tcdm.add = ld_addr_i[2]; ld_gnt_o[2] = hs_s; end
      2'd3: begin
        tcdm.wen  = 1'b0;
        tcdm.add  = st_addr_i;
        tcdm.data = st_data_i;
        tcdm.be   = st_be_i;
        st_gnt_o  = hs_s;
      end
      default: tcdm.add = ld_addr_i[0];
    endcase
  end

  // Route a read response to the source at the head of the ID FIFO.
  always_comb begin
    ld_rvalid_o = 3'b000;
    if (pop_s) begin
      case (id_mem_r[rd_ptr_r])
        2'd0:    ld_rvalid_o = 3'b001;
        2'd1:    ld_rvalid_o = 3'b010;
        2'd2:    ld_rvalid_o = 3'b100;
        default: ld_rvalid_o = 3'b000;
      endcase
    end else begin
      ld_rvalid_o = 3'b000;
    end
  end

  // Arbitration state, ID FIFO, outstanding count, starvation counter and sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_r       <= 2'd0;
      lock_r     <= 1'b0;
      lock_idx_r <= 2'd0;
      starve_r   <= {STV_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      err_r      <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTST); i++) id_mem_r[i] <= 2'd0;
    end else if (clear_i) begin
      rr_r       <= 2'd0;
      lock_r     <= 1'b0;
      lock_idx_r <= 2'd0;
      starve_r   <= {STV_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      err_r      <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTST); i++) id_mem_r[i] <= 2'd0;
    end else begin
      if (hs_s) begin
        rr_r   <= sel_idx_s + 2'd1;
        lock_r <= 1'b0;
      end else if (sel_valid_s) begin
        lock_r     <= 1'b1;
        lock_idx_r <= sel_idx_s;
      end
      if (ld_hs_s) begin
        id_mem_r[wr_ptr_r] <= sel_idx_s;
        wr_ptr_r           <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      case ({ld_hs_s, pop_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
      if (!z_priority_i || ld_hs_s) begin
        starve_r <= {STV_W{1'b0}};
      end else if ((|load_elig_s) && !starve_sat_s) begin
        starve_r <= starve_r + {{(STV_W-1){1'b0}}, 1'b1};
      end
      if (spurious_s) err_r <= 1'b1;
    end
  end

endmodule
